// File: rtl/ct_spsram_param.sv
// Parametrised single-port synchronous SRAM with a post-reset init sweep.
// Optional second output register stage: define CT_SPSRAM_OUTREG_EN.
module ct_spsram_param #(
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter int unsigned           DATA_WIDTH = 92,
  parameter int unsigned           WE_WIDTH   = 92,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                  CLK,
  input  logic                  RST_B,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic [WE_WIDTH-1:0]   WEN,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  INIT_DONE
);

  localparam int unsigned           DEPTH    = 2 ** ADDR_WIDTH;
  localparam int unsigned           GRAN     = DATA_WIDTH / WE_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  generate
    if ((WE_WIDTH > DATA_WIDTH) || ((DATA_WIDTH % WE_WIDTH) != 0)) begin : g_bad_cfg
      $error("ct_spsram_param: WE_WIDTH must divide DATA_WIDTH");
    end
  endgenerate

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    init_done_q, init_done_d;
  logic [DATA_WIDTH-1:0]   rd_q, rd_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [WE_WIDTH-1:0]     wr_mask;
  logic                    ext_rd;
  logic                    ext_wr;

  // External accesses only qualify once the sweep is done; an unknown CEN
  // never qualifies, so garbage on the bus cannot reach the array or Q.
  always_comb begin
    ext_rd      = 1'b0;
    ext_wr      = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    rd_d        = rd_q;
    wr_en       = 1'b0;
    wr_addr     = cnt_q;
    wr_data     = INIT_VAL;
    wr_mask     = '1;

    if ((state_q == ST_READY) && (CEN == 1'b0)) begin
      if (GWEN == 1'b1) begin
        ext_rd = 1'b1;
      end else if (GWEN == 1'b0) begin
        ext_wr = 1'b1;
      end
    end

    case (state_q)
      ST_INIT: begin
        wr_en = 1'b1;
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == CNT_LAST) begin
          state_d     = ST_READY;
          init_done_d = 1'b1;
        end
      end
      ST_READY: begin
        if (ext_wr) begin
          wr_en   = 1'b1;
          wr_addr = A;
          wr_data = D;
          wr_mask = ~WEN;
        end
        if (ext_rd) begin
          rd_d = mem_q[A];
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rd_q        <= rd_d;
    end
  end

  // Array has no reset of its own; nothing lands while reset is held.
  always_ff @(posedge CLK) begin
    if (RST_B && wr_en) begin
      for (int i = 0; i < WE_WIDTH; i++) begin
        if (wr_mask[i]) begin
          mem_q[wr_addr][i*GRAN +: GRAN] <= wr_data[i*GRAN +: GRAN];
        end
      end
    end
  end

`ifdef CT_SPSRAM_OUTREG_EN
  logic [DATA_WIDTH-1:0] out_q, out_d;

  always_comb begin
    out_d = rd_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign Q = out_q;
`else
  assign Q = rd_q;
`endif

  assign INIT_DONE = init_done_q;

endmodule

// File: tb/tb_ct_spsram_param.sv
// Self-checking bench for ct_spsram_param: init timing, masking, latency and
// randomized traffic against a behavioural array model.
module tb_ct_spsram_param;

`ifdef CT_SPSRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic CLK;
  logic RST_B;

  // dut0: 16 x 16, byte lanes, INIT 0xA5
  logic [3:0]  a0;
  logic        cen0, gwen0;
  logic [15:0] d0;
  logic [1:0]  wen0;
  logic [15:0] q0;
  logic        done0;

  // dut1: 1024 x 92, bit mask, INIT 0
  logic [9:0]  a1;
  logic        cen1, gwen1;
  logic [91:0] d1;
  logic [91:0] wen1;
  logic [91:0] q1;
  logic        done1;

  // dut2: 16 x 64, byte mask, INIT 0
  logic [3:0]  a2;
  logic        cen2, gwen2;
  logic [63:0] d2;
  logic [7:0]  wen2;
  logic [63:0] q2;
  logic        done2;

  ct_spsram_param #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .WE_WIDTH(2), .INIT_VAL(16'h00A5)) u_dut0 (
    .CLK(CLK), .RST_B(RST_B), .A(a0), .CEN(cen0), .GWEN(gwen0), .D(d0), .WEN(wen0),
    .Q(q0), .INIT_DONE(done0));

  ct_spsram_param #(.ADDR_WIDTH(10), .DATA_WIDTH(92), .WE_WIDTH(92), .INIT_VAL(92'h0)) u_dut1 (
    .CLK(CLK), .RST_B(RST_B), .A(a1), .CEN(cen1), .GWEN(gwen1), .D(d1), .WEN(wen1),
    .Q(q1), .INIT_DONE(done1));

  ct_spsram_param #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .WE_WIDTH(8), .INIT_VAL(64'h0)) u_dut2 (
    .CLK(CLK), .RST_B(RST_B), .A(a2), .CEN(cen2), .GWEN(gwen2), .D(d2), .WEN(wen2),
    .Q(q2), .INIT_DONE(done2));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Behavioural model of dut0: plain array plus the read-value history.
  logic [15:0] mdl_mem [16];
  logic [15:0] s1, s1_prev, exp_q0;

  task automatic cyc0(input logic cen, input logic gwen, input logic [3:0] a,
                      input logic [15:0] d, input logic [1:0] wen);
    cen0 = cen; gwen0 = gwen; a0 = a; d0 = d; wen0 = wen;
    tick();
    s1_prev = s1;
    if (!cen && gwen) begin
      s1 = mdl_mem[a];
    end else if (!cen && !gwen) begin
      if (!wen[0]) mdl_mem[a][7:0]  = d[7:0];
      if (!wen[1]) mdl_mem[a][15:8] = d[15:8];
    end
    exp_q0 = (LAT == 1) ? s1 : s1_prev;
    cen0 = 1'b1;
  endtask

  typedef struct {
    logic        cen;
    logic        gwen;
    logic [3:0]  a;
    logic [15:0] d;
    logic [1:0]  wen;
    logic [15:0] exp_q;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [15:0] prev;
    logic [31:0] r;
    logic [31:0] rd;
    logic [91:0] exp92;

    tbl[0]  = '{1'b0, 1'b0, 4'h1, 16'h0011, 2'b00, 16'h00A5};
    tbl[1]  = '{1'b0, 1'b0, 4'h2, 16'h0022, 2'b00, 16'h00A5};
    tbl[2]  = '{1'b0, 1'b0, 4'h3, 16'h0033, 2'b00, 16'h00A5};
    tbl[3]  = '{1'b0, 1'b1, 4'h1, 16'h0000, 2'b00, 16'h0011};
    tbl[4]  = '{1'b0, 1'b1, 4'h2, 16'h0000, 2'b00, 16'h0022};
    tbl[5]  = '{1'b0, 1'b1, 4'h3, 16'h0000, 2'b00, 16'h0033};
    tbl[6]  = '{1'b0, 1'b0, 4'h4, 16'hBEEF, 2'b01, 16'h0033};
    tbl[7]  = '{1'b0, 1'b1, 4'h4, 16'h0000, 2'b00, 16'hBEA5};
    tbl[8]  = '{1'b0, 1'b0, 4'h4, 16'h1234, 2'b11, 16'hBEA5};
    tbl[9]  = '{1'b0, 1'b1, 4'h4, 16'h0000, 2'b00, 16'hBEA5};
    tbl[10] = '{1'b1, 1'b0, 4'h4, 16'hFFFF, 2'b00, 16'hBEA5};
    tbl[11] = '{1'b1, 1'b1, 4'h1, 16'h0000, 2'b00, 16'hBEA5};
    tbl[12] = '{1'b0, 1'b1, 4'h4, 16'h0000, 2'b00, 16'hBEA5};
    tbl[13] = '{1'b0, 1'b0, 4'h0, 16'h5A5A, 2'b10, 16'hBEA5};
    tbl[14] = '{1'b0, 1'b1, 4'h0, 16'h0000, 2'b00, 16'h005A};
    tbl[15] = '{1'b0, 1'b1, 4'h5, 16'h0000, 2'b00, 16'h00A5};

    // Init phase: dut0 sees a write to A=5 every cycle, which must be ignored.
    RST_B = 1'b0;
    cen0 = 1'b0; gwen0 = 1'b0; a0 = 4'h5; d0 = 16'hFFFF; wen0 = 2'b00;
    cen1 = 1'b1; gwen1 = 1'b1; a1 = '0; d1 = '0; wen1 = '1;
    cen2 = 1'b1; gwen2 = 1'b1; a2 = '0; d2 = '0; wen2 = '1;
    tick();
    tick();
    check("rst_done", 128'(done0), 128'(1'b0));
    check("rst_q", 128'(q0), 128'(16'h0));

    RST_B = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("sweep1_done", 128'(done0), 128'(1'b0));
      check("sweep1_q", 128'(q0), 128'(16'h0));
    end
    RST_B = 1'b0;
    tick();
    check("midrst_done", 128'(done0), 128'(1'b0));
    RST_B = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("sweep2_done", 128'(done0), 128'((k == 16) ? 1'b1 : 1'b0));
      check("sweep2_q", 128'(q0), 128'(16'h0));
    end
    cen0 = 1'b1;

    for (int i = 0; i < 16; i++) mdl_mem[i] = 16'h00A5;
    s1 = '0;
    s1_prev = '0;

    for (int i = 0; i < 16; i++) begin
      cyc0(1'b0, 1'b1, 4'(i), 16'h0, 2'b00);
      check("init_read", 128'(q0), 128'(exp_q0));
      if (i >= LAT - 1) check("init_val", 128'(mdl_mem[i]), 128'(16'h00A5));
    end

    prev = 16'h00A5;
    for (int i = 0; i < 16; i++) begin
      cyc0(tbl[i].cen, tbl[i].gwen, tbl[i].a, tbl[i].d, tbl[i].wen);
      check($sformatf("tbl%0d", i), 128'(q0), 128'((LAT == 1) ? tbl[i].exp_q : prev));
      prev = tbl[i].exp_q;
    end

    for (int i = 0; i < 400; i++) begin
      r  = $urandom;
      rd = $urandom;
      cyc0((r[1:0] == 2'b00), r[2], r[6:3], rd[15:0], r[8:7]);
      check("rand_q", 128'(q0), 128'(exp_q0));
    end
    check("ready_stays", 128'(done0), 128'(1'b1));

    // dut1 takes 1024 sweep cycles; bounded wait.
    for (int i = 0; i < 2000 && !done1; i++) tick();
    check("d92_init_done", 128'(done1), 128'(1'b1));

    cen1 = 1'b0; gwen1 = 1'b0; a1 = 10'h3FF; d1 = '1;
    wen1 = {{46{1'b1}}, {46{1'b0}}};
    tick();
    cen1 = 1'b1;
    repeat (LAT - 1) tick();
    check("d92_q_hold", 128'(q1), 128'(92'h0));
    cen1 = 1'b0; gwen1 = 1'b1; a1 = 10'h3FF;
    tick();
    cen1 = 1'b1;
    repeat (LAT - 1) tick();
    exp92 = {{46{1'b0}}, {46{1'b1}}};
    check("d92_masked", 128'(q1), 128'(exp92));

    cen2 = 1'b0; gwen2 = 1'b0; a2 = 4'h2; d2 = 64'hDEADBEEFCAFEF00D; wen2 = 8'h00;
    tick();
    cen2 = 1'b0; gwen2 = 1'b1; a2 = 4'h2;
    tick();
    cen2 = 1'b1;
    repeat (LAT - 1) tick();
    check("d64_full", 128'(q2), 128'(64'hDEADBEEFCAFEF00D));
    cen2 = 1'b0; gwen2 = 1'b0; a2 = 4'h7; d2 = 64'h1122334455667788; wen2 = 8'b11110000;
    tick();
    cen2 = 1'b1;
    repeat (LAT) tick();
    check("d64_q_hold", 128'(q2), 128'(64'hDEADBEEFCAFEF00D));
    cen2 = 1'b0; gwen2 = 1'b1; a2 = 4'h7;
    tick();
    cen2 = 1'b1;
    repeat (LAT - 1) tick();
    check("d64_bytes", 128'(q2), 128'(64'h0000000055667788));
    cen2 = 1'b1; gwen2 = 1'b0; a2 = 4'h7; d2 = '1; wen2 = 8'h00;
    tick();
    repeat (LAT) tick();
    check("d64_cen_q", 128'(q2), 128'(64'h0000000055667788));
    cen2 = 1'b0; gwen2 = 1'b1; a2 = 4'h2;
    tick();
    cen2 = 1'b0; gwen2 = 1'b1; a2 = 4'h7;
    tick();
    cen2 = 1'b1;
    repeat (LAT - 1) tick();
    check("d64_cen_mem", 128'(q2), 128'(64'h0000000055667788));
    check("d64_init_done", 128'(done2), 128'(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ct_spsram_param.md
Name: ct_spsram_param

Overview:
- Parametrised single-port synchronous SRAM model.
- Generalises the fixed-size CPU SRAM wrappers (for example 1024x92) to arbitrary depth, data width and write-mask granularity.
- Adds a post-reset hardware init sweep with a completion flag, plus an optional output pipeline register.
- Used as the common behavioural/FPGA backing store under cache and tag-array wrappers.

Parameters:
ADDR_WIDTH, 10, address bits; DEPTH = 2**ADDR_WIDTH entries
DATA_WIDTH, 92, bits per entry
WE_WIDTH, 92, write-mask bits; must divide DATA_WIDTH; each mask bit covers GRAN = DATA_WIDTH/WE_WIDTH data bits
INIT_VAL, 0, value of width DATA_WIDTH written to every entry by the init sweep

Ports:
CLK  input  1  clock, all logic on rising edge
RST_B  input  1  synchronous active-low reset
A  input  ADDR_WIDTH  access address
CEN  input  1  chip enable, active low
GWEN  input  1  global write enable, active low (0=write, 1=read)
D  input  DATA_WIDTH  write data
WEN  input  WE_WIDTH  write mask, active low; bit i governs D[i*GRAN +: GRAN]
Q  output  DATA_WIDTH  read data
INIT_DONE  output  1  high once init sweep complete; memory accessible

Behaviour:
- Interface: one clock (CLK); reset RST_B is synchronous and active-low.
- Reset (RST_B=0 sampled at a rising edge):
  - Q=0, INIT_DONE=0, init counter=0, FSM enters INIT.
  - Array contents are not reset directly; the INIT sweep overwrites them.
- FSM states: INIT, READY.
  - INIT: each cycle writes INIT_VAL to the entry at the counter, then increments the counter.
  - When the counter = DEPTH-1 is written, go to READY next cycle and set INIT_DONE=1 on that same edge.
  - Sweep takes exactly DEPTH cycles. INIT_DONE rises DEPTH cycles after the reset-release edge.
- During INIT:
  - External CEN/GWEN/WEN/A/D are ignored; no external write lands.
  - Q holds 0.
- READY is terminal until the next reset. Reset asserted mid-sweep restarts the sweep from entry 0.
- Read in READY (CEN=0, GWEN=1 at edge N):
  - Q = mem[A] after edge N (1-cycle latency).
  - Q holds that value until the next read completes.
- Write in READY (CEN=0, GWEN=0 at edge N):
  - For each i with WEN[i]=0, mem[A] slice i <= D slice i.
  - Slices with WEN[i]=1 are unchanged.
  - Q is unchanged (no write-through).
- WEN=all-ones with GWEN=0 is a legal no-op write; Q is still held.
- CEN=1: no access, Q held, array unchanged, regardless of GWEN/WEN/A/D.
- Read-after-write to the same address on the next cycle returns the newly written data.
- A spans the full DEPTH, so no out-of-range address exists; there is no wrap logic.
- X/undriven inputs while CEN=1 must not corrupt the array or Q.
- Elaboration check: error if DATA_WIDTH % WE_WIDTH != 0 or WE_WIDTH > DATA_WIDTH.

Optional Feature:
- Macro: CT_SPSRAM_OUTREG_EN
- Defined:
  - A second register stage follows the array read register.
  - Read latency is 2 (Q valid after edge N+1 for a read at edge N).
  - Both stages reset to 0.
  - The output stage always loads from stage 1, so Q shows stage 1's held value one cycle late.
  - INIT_DONE timing is unchanged.
- Undefined: single register stage, latency 1, as above.

Test Plan:
- Reset / init timing (ADDR_WIDTH=4, INIT_VAL=0xA5):
  - Hold RST_B=0 2 cycles, release.
  - INIT_DONE=0 for exactly 16 cycles, then 1.
  - Reading all 16 entries returns 0xA5; Q=0 throughout INIT.
- Masked write (DATA_WIDTH=92, WE_WIDTH=92; mem[0x3FF]=INIT_VAL=0):
  - Write A=0x3FF, D=all-ones, WEN bits[45:0]=0, bits[91:46]=1.
  - Read 0x3FF gives upper 46 bits 0, lower 46 bits 1.
- Byte-granular write (DATA_WIDTH=64, WE_WIDTH=8):
  - Write D=0x1122334455667788 with WEN=8'b11110000.
  - Readback = 0x0000000055667788.
  - Q after the write cycle is unchanged.
- Ignore during init and disabled cycles:
  - Drive CEN=0/GWEN=0 write to A=5 during INIT; after INIT_DONE, read A=5 returns INIT_VAL.
  - Cycle with CEN=1 and GWEN=0 leaves mem and Q unchanged.
- Mid-sweep reset:
  - Assert RST_B=0 at sweep cycle 7; INIT_DONE stays 0.
  - After release, the sweep takes a full DEPTH cycles.
- Latency, with and without CT_SPSRAM_OUTREG_EN:
  - Back-to-back reads A=1,2,3 (values 0x11,0x22,0x33).
  - Q sequence appears at latency 1 without the macro, latency 2 with it.
